// File: rtl/blockade_dl_pkg.sv
// ---------------------------------------------------------------------------
// blockade_dl_pkg
// Shared types and constants for the blockade ROM download path.
//   dl_state_t   : one-hot download sequencer states
//   DL_ADDR_W    : default ROM write address width
//   DL_ROM_INDEX : default ioctl_index that selects the ROM image
//   dl_cnt_w()   : width of an occupancy counter able to hold 0..depth
// ---------------------------------------------------------------------------
package blockade_dl_pkg;

    localparam int         DL_ADDR_W    = 14;
    localparam logic [7:0] DL_ROM_INDEX = 8'd0;

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        LOAD  = 5'b00010,
        DRAIN = 5'b00100,
        HOLD  = 5'b01000,
        RUN   = 5'b10000
    } dl_state_t;

    // The count must reach 'depth' itself, so one bit more than the pointer.
    function automatic int dl_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dl_fifo.sv
// ---------------------------------------------------------------------------
// dl_fifo
// Synchronous FIFO holding {address, byte} tuples between the ioctl side and
// the ROM sink. Head entry is presented combinationally on dout.
// Ports:
//   clk_4m, reset : clock, synchronous active-high reset (empties the FIFO)
//   push, din     : write din when push=1 and not full
//   pop, dout     : dout is the head entry; pop=1 and not empty retires it
//   count         : current occupancy 0..DEPTH
//   full, empty   : occupancy flags
// ---------------------------------------------------------------------------
module dl_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk_4m,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: storage is deliberately left out of reset; the pointers and count
    // alone define which entries are valid, so the array can map onto plain RAM.
    always_ff @(posedge clk_4m) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // in the block samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_4m) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rom_download_ctrl.sv
// ---------------------------------------------------------------------------
// rom_download_ctrl
// Sequences the HPS ioctl ROM download into the blockade core load port.
// Matching bytes (ioctl_index == ROM_INDEX, address inside the image) pass
// through a one-stage input register and a small FIFO to a registered
// dn_addr/dn_data/dn_wr handshake. ioctl_wait throttles the host when the
// sink stalls, and core_reset is held from download start until the load
// has drained and RELEASE_DELAY further cycles have passed.
//
// Optional feature: define ROM_CHECKSUM_EN to add an 8-bit running sum of
// every byte the sink accepts, exposed on the checksum port.
//
// Ports:
//   clk_4m, reset   : clock, synchronous active-high reset
//   ioctl_download  : host download window
//   ioctl_wr        : one-cycle byte strobe
//   ioctl_addr      : byte address (25 bits)
//   ioctl_dout      : byte data
//   ioctl_index     : image selector
//   ioctl_wait      : host must hold off the next ioctl_wr
//   dn_addr/dn_data : ROM write address / data to the core
//   dn_wr           : write valid, held until dn_ready
//   dn_ready        : sink accepts the write this cycle
//   core_reset      : reset to the blockade core
//   rom_loaded      : a complete image is resident
//   load_error      : sticky overflow / out-of-range flag
//   checksum        : byte sum of the accepted image (ROM_CHECKSUM_EN only)
// ---------------------------------------------------------------------------
module rom_download_ctrl
    import blockade_dl_pkg::*;
#(
    parameter int         FIFO_DEPTH    = 4,
    parameter int         ADDR_W        = DL_ADDR_W,
    parameter int         ROM_BYTES     = 16384,
    parameter logic [7:0] ROM_INDEX     = DL_ROM_INDEX,
    parameter int         RELEASE_DELAY = 16
) (
    input  logic              clk_4m,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [7:0]        dn_data,
    output logic              dn_wr,
    input  logic              dn_ready,
    output logic              core_reset,
    output logic              rom_loaded,
    output logic              load_error
`ifdef ROM_CHECKSUM_EN
    ,
    output logic [7:0]        checksum
`endif
);

    localparam int                ENTRY_W    = ADDR_W + 8;
    localparam int                CNT_W      = dl_cnt_w(FIFO_DEPTH);
    localparam int                DLY_W      = $clog2(RELEASE_DELAY + 1);
    localparam logic [24:0]       ROM_LIMIT  = 25'(ROM_BYTES);
    localparam logic [CNT_W-1:0]  WAIT_LEVEL = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [DLY_W-1:0]  DELAY_LOAD = DLY_W'(RELEASE_DELAY - 1);

    dl_state_t          state;
    logic [DLY_W-1:0]   delay_cnt;

    // Edge detectors for the download window
    logic               match_q;
    logic               download_q;

    // Input register: one accepted byte in flight toward the FIFO
    logic               in_wr_q;
    logic [ADDR_W-1:0]  in_addr_q;
    logic [7:0]         in_data_q;

    // FIFO interface
    logic [ENTRY_W-1:0] fifo_dout;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;

    // Combinational decode
    logic               match;
    logic               load_entry;
    logic               addr_ok;
    logic               in_sample;
    logic               oor_wr;
    logic               overflow;
    logic               push;
    logic               pop;
    logic               drain_done;
    logic [CNT_W-1:0]   count_nxt;

    // NOTE: every signal gets a default first, so no path through this block
    // can leave a value unassigned and infer a latch.
    always_comb begin
        match      = 1'b0;
        load_entry = 1'b0;
        addr_ok    = 1'b0;
        in_sample  = 1'b0;
        oor_wr     = 1'b0;
        overflow   = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        drain_done = 1'b0;
        count_nxt  = fifo_count;

        match      = ioctl_download && (ioctl_index == ROM_INDEX);
        load_entry = match && !match_q && ((state == IDLE) || (state == RUN));

        addr_ok    = (ioctl_addr < ROM_LIMIT);
        in_sample  = (state == LOAD) && ioctl_wr && addr_ok;
        oor_wr     = (state == LOAD) && ioctl_wr && !addr_ok;

        // A byte already in the input register is lost only if the FIFO is
        // full; a same-cycle pop does not rescue it.
        overflow   = in_wr_q && fifo_full;
        push       = in_wr_q && !fifo_full;

        // The output register refills whenever it is free or being accepted.
        pop        = !fifo_empty && (!dn_wr || dn_ready);

        count_nxt  = fifo_count + CNT_W'(push) - CNT_W'(pop);

        drain_done = fifo_empty && !dn_wr && !in_wr_q;
    end

    dl_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_4m (clk_4m),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .din    ({in_addr_q, in_data_q}),
        .dout   (fifo_dout),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk_4m) begin
        if (reset) begin
            state      <= IDLE;
            delay_cnt  <= '0;
            match_q    <= 1'b0;
            download_q <= 1'b0;
            in_wr_q    <= 1'b0;
            in_addr_q  <= '0;
            in_data_q  <= '0;
            ioctl_wait <= 1'b0;
            dn_addr    <= '0;
            dn_data    <= '0;
            dn_wr      <= 1'b0;
            core_reset <= 1'b1;
            rom_loaded <= 1'b0;
            load_error <= 1'b0;
`ifdef ROM_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            match_q    <= match;
            download_q <= ioctl_download;

            in_wr_q <= in_sample;
            if (in_sample) begin
                in_addr_q <= ioctl_addr[ADDR_W-1:0];
                in_data_q <= ioctl_dout;
            end

            // Output register: stable while dn_wr=1 and the sink stalls.
            if (pop) begin
                dn_wr   <= 1'b1;
                dn_addr <= fifo_dout[ENTRY_W-1:8];
                dn_data <= fifo_dout[7:0];
            end else if (dn_ready) begin
                dn_wr   <= 1'b0;
            end

            // Raised as soon as the post-edge occupancy reaches DEPTH-1, so
            // the one byte already sampled into the input register still fits.
            ioctl_wait <= ((state == LOAD) || (state == DRAIN)) &&
                          (count_nxt >= WAIT_LEVEL);

            if (load_entry) begin
                load_error <= 1'b0;
            end else if (oor_wr || overflow) begin
                load_error <= 1'b1;
            end

`ifdef ROM_CHECKSUM_EN
            if (load_entry) begin
                checksum <= '0;
            end else if (dn_wr && dn_ready) begin
                checksum <= checksum + dn_data;
            end
`endif

            case (state)
                IDLE: begin
                    if (load_entry) begin
                        state      <= LOAD;
                        core_reset <= 1'b1;
                        rom_loaded <= 1'b0;
                    end
                end
                LOAD: begin
                    if (download_q && !ioctl_download) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state     <= HOLD;
                        delay_cnt <= DELAY_LOAD;
                    end
                end
                HOLD: begin
                    if (delay_cnt == '0) begin
                        state      <= RUN;
                        core_reset <= 1'b0;
                        rom_loaded <= 1'b1;
                    end else begin
                        delay_cnt <= delay_cnt - DLY_W'(1);
                    end
                end
                RUN: begin
                    if (load_entry) begin
                        state      <= LOAD;
                        core_reset <= 1'b1;
                        rom_loaded <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
